// File: rtl/game_pkg.sv
// Shared tic-tac-toe definitions: cell codes, board layout, FSM states, win-line table.
package game_pkg;
  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef logic [1:0]             cell_t;
  typedef logic [3:0]             pos_t;
  typedef logic [2*NUM_CELLS-1:0] board_t;

  localparam cell_t CELL_EMPTY = 2'd0;
  localparam cell_t CELL_X     = 2'd1;
  localparam cell_t CELL_O     = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOVE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  // Ordered by win priority: rows, columns, main diagonal, anti-diagonal.
  localparam pos_t WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic cell_t cell_get(board_t b, pos_t idx);
    cell_t v;
    v = CELL_EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == pos_t'(i)) v = b[2*i +: 2];
    end
    return v;
  endfunction

  function automatic cell_t other_player(cell_t p);
    return (p == CELL_X) ? CELL_O : CELL_X;
  endfunction
endpackage

// File: rtl/game_controller_if.sv
// Move handshake and game-status bundle; master drives moves/start, slave is the controller.
interface game_controller_if;
  logic              start;
  logic              move_valid;
  game_pkg::pos_t    move_pos;
  logic              move_ready;
  logic              move_ack;
  logic              move_err;
  game_pkg::board_t  board;
  game_pkg::cell_t   turn;
  game_pkg::cell_t   winner;
  logic              game_over;
  logic              draw;
  logic              timeout;

  modport master (
    output start, move_valid, move_pos,
    input  move_ready, move_ack, move_err, board, turn, winner, game_over, draw, timeout
  );

  modport slave (
    input  start, move_valid, move_pos,
    output move_ready, move_ack, move_err, board, turn, winner, game_over, draw, timeout
  );
endinterface

// File: rtl/game_controller_board_evaluator.sv
// Combinational board scan: first winning line in priority order, and board-full flag.
// Zero latency; no handshake, outputs follow the board input.
module board_evaluator
  import game_pkg::*;
(
  input  board_t i_board,
  output cell_t  o_winner,
  output logic   o_full
);
  // Scan from the last line down so the lowest-index match is the one that sticks.
  always_comb begin
    o_winner = CELL_EMPTY;
    for (int l = NUM_LINES - 1; l >= 0; l--) begin
      if ((cell_get(i_board, WIN_LINES[l][0]) != CELL_EMPTY) &&
          (cell_get(i_board, WIN_LINES[l][0]) == cell_get(i_board, WIN_LINES[l][1])) &&
          (cell_get(i_board, WIN_LINES[l][0]) == cell_get(i_board, WIN_LINES[l][2]))) begin
        o_winner = cell_get(i_board, WIN_LINES[l][0]);
      end
    end
  end

  always_comb begin
    o_full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (i_board[2*i +: 2] == CELL_EMPTY) o_full = 1'b0;
    end
  end
endmodule

// File: rtl/game_controller.sv
// Tic-tac-toe controller: accepted move -> next move_ready after 3 cycles (ack, APPLY, CHECK);
// move_ready only in WAIT_MOVE. Optional turn forfeit when MOVE_TIMEOUT_EN is defined.
module game_controller
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  game_controller_if.slave gc
);
  state_t r_state, w_state_nxt;
  board_t r_board, w_board_nxt;
  cell_t  r_turn, w_turn_nxt;
  cell_t  r_winner, w_winner_nxt;
  logic   r_draw, w_draw_nxt;
  pos_t   r_pos, w_pos_nxt;

  logic   w_ready, w_hs, w_legal;
  logic   w_ack, w_err, w_timeout, w_cnt_clr, w_tmo_hit;
  cell_t  w_eval_winner;
  logic   w_eval_full;

  board_evaluator u_eval (
    .i_board  (r_board),
    .o_winner (w_eval_winner),
    .o_full   (w_eval_full)
  );

  assign w_ready = (r_state == WAIT_MOVE);
  assign w_hs    = gc.move_valid && w_ready;
  assign w_legal = (gc.move_pos <= pos_t'(NUM_CELLS - 1)) &&
                   (cell_get(r_board, gc.move_pos) == CELL_EMPTY);

`ifdef MOVE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Hit on the idle cycle that would bring the count up to the limit; any handshake wins.
  assign w_tmo_hit = w_ready && !w_hs && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) r_cnt <= '0;
    else if (w_ready && !w_hs) r_cnt <= r_cnt + 1'b1;
  end
`else
  logic w_unused_cfg;
  assign w_tmo_hit    = 1'b0;
  assign w_unused_cfg = ^{w_cnt_clr, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_board_nxt  = r_board;
    w_turn_nxt   = r_turn;
    w_winner_nxt = r_winner;
    w_draw_nxt   = r_draw;
    w_pos_nxt    = r_pos;
    w_ack        = 1'b0;
    w_err        = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_clr    = 1'b0;

    if (gc.start) begin
      w_state_nxt  = WAIT_MOVE;
      w_board_nxt  = '0;
      w_turn_nxt   = CELL_X;
      w_winner_nxt = CELL_EMPTY;
      w_draw_nxt   = 1'b0;
      w_cnt_clr    = 1'b1;
    end else begin
      case (r_state)
        IDLE: ;
        WAIT_MOVE: begin
          if (w_hs) begin
            if (w_legal) begin
              w_ack       = 1'b1;
              w_pos_nxt   = gc.move_pos;
              w_state_nxt = APPLY;
            end else begin
              w_err = 1'b1;
            end
          end else if (w_tmo_hit) begin
            w_timeout  = 1'b1;
            w_turn_nxt = other_player(r_turn);
            w_cnt_clr  = 1'b1;
          end
        end
        APPLY: begin
          for (int i = 0; i < NUM_CELLS; i++) begin
            if (r_pos == pos_t'(i)) w_board_nxt[2*i +: 2] = r_turn;
          end
          w_state_nxt = CHECK;
        end
        CHECK: begin
          w_winner_nxt = w_eval_winner;
          w_draw_nxt   = w_eval_full && (w_eval_winner == CELL_EMPTY);
          if ((w_eval_winner != CELL_EMPTY) || w_eval_full) begin
            w_state_nxt = DONE;
          end else begin
            w_turn_nxt  = other_player(r_turn);
            w_state_nxt = WAIT_MOVE;
            w_cnt_clr   = 1'b1;
          end
        end
        DONE: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_board  <= '0;
      r_turn   <= CELL_EMPTY;
      r_winner <= CELL_EMPTY;
      r_draw   <= 1'b0;
      r_pos    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_board  <= w_board_nxt;
      r_turn   <= w_turn_nxt;
      r_winner <= w_winner_nxt;
      r_draw   <= w_draw_nxt;
      r_pos    <= w_pos_nxt;
    end
  end

  assign gc.move_ready = w_ready;
  assign gc.move_ack   = w_ack && !rst;
  assign gc.move_err   = w_err && !rst;
  assign gc.timeout    = w_timeout && !rst;
  assign gc.board      = r_board;
  assign gc.turn       = w_ready ? r_turn : CELL_EMPTY;
  assign gc.winner     = r_winner;
  assign gc.game_over  = (r_state == DONE);
  assign gc.draw       = r_draw;
endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255; maximum cycles a player may wait in WAIT_MOVE before forfeiting the turn (only with MOVE_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new game; clears the board; X moves first.
REQ-005 move_valid  input  1  the current player presents a move.
REQ-006 move_pos  input  4  target cell index 0..8, row-major.
REQ-007 move_ready  output  1  high only in WAIT_MOVE.
REQ-008 move_ack  output  1  one-cycle pulse when a move is accepted.
REQ-009 move_err  output  1  one-cycle pulse when a move is rejected.
REQ-010 board  output  18  nine 2-bit cells; cell i at bits [2i+1:2i]; 0 empty, 1 X, 2 O.
REQ-011 turn  output  2  player to move (1 X, 2 O); 0 outside WAIT_MOVE.
REQ-012 winner  output  2  0 none, 1 X, 2 O; valid in DONE.
REQ-013 game_over  output  1  high in DONE.
REQ-014 draw  output  1  high in DONE when the board is full with no winner.
REQ-015 timeout  output  1  one-cycle pulse on a turn forfeit (constant 0 without MOVE_TIMEOUT_EN).

Function
REQ-016 The FSM shall have the states IDLE, WAIT_MOVE, APPLY, CHECK and DONE.
REQ-017 IDLE -> WAIT_MOVE on start, with the board cleared and turn=X.
REQ-018 In WAIT_MOVE, a handshake (move_valid && move_ready) with move_pos<=8 and an empty target cell shall pulse move_ack and go to APPLY; other signals on that cycle shall have no effect.
REQ-019 A handshake with move_pos>8 or an occupied target cell shall pulse move_err, leave the board unchanged, and keep the FSM in WAIT_MOVE with the same player.
REQ-020 APPLY shall write turn into the latched cell, then go to CHECK.
REQ-021 CHECK shall evaluate the updated board and register winner and draw: on a win or a full board go to DONE; otherwise toggle turn and return to WAIT_MOVE.
REQ-022 Acceptance to the next move_ready shall be exactly 3 cycles: ack cycle, APPLY, CHECK.
REQ-023 Win priority (first match registered): rows 0-2, then columns 0-2, then diagonal 0-4-8, then diagonal 2-4-6.
REQ-024 draw shall be asserted only with winner=0; a win on the ninth move shall report the winner with draw=0.
REQ-025 DONE shall hold board, winner, draw and game_over until start.
REQ-026 start in any state shall return the block to WAIT_MOVE on the next cycle with the board cleared and turn=X; start has priority over a simultaneous move, and that move shall produce neither ack nor err.
REQ-027 move_ack, move_err and timeout shall be mutually exclusive in any cycle.

Reset
REQ-028 With rst high at a rising edge: state=IDLE, board=0, turn=0, winner=0, game_over=0, draw=0, move_ack=0, move_err=0, timeout=0, timeout counter=0.
REQ-029 rst shall override start and any in-progress move; a latched but unapplied move shall be discarded.

Configuration
REQ-030 With MOVE_TIMEOUT_EN defined, a counter shall clear on entry to WAIT_MOVE and increment each WAIT_MOVE cycle without a handshake; when it reaches TIMEOUT_CYCLES the block shall pulse timeout, toggle turn, clear the counter, and leave the board unchanged.
REQ-031 A handshake in the same cycle the counter reaches TIMEOUT_CYCLES shall take priority over the timeout.
REQ-032 Without MOVE_TIMEOUT_EN, the counter logic shall be absent, timeout shall be tied to 0, and WAIT_MOVE shall wait indefinitely.

Structure
REQ-033 A shared package game_pkg shall hold: cell encodings (CELL_EMPTY, CELL_X, CELL_O), NUM_CELLS=9, the FSM state enum, and the 8-entry win-line index table.
REQ-034 One combinational sub-module, board_evaluator (board in; winner, full out), shall be instantiated and its outputs registered in CHECK.

Verification
REQ-035 rst, then start; X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 -> winner=1, game_over=1, draw=0; board cells 0,1,2=1 and cells 3,4=2.
REQ-036 The nine-move sequence 0,1,2,4,3,5,7,6,8 -> draw=1, winner=0, game_over=1.
REQ-037 X plays 4, then O tries cell 4 -> move_err pulse, board unchanged, turn stays 2; O tries cell 9 -> move_err pulse.
REQ-038 start together with move_valid (pos 0) mid-game -> board=0 and turn=1 next cycle, no move_ack.
REQ-039 With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=4, X idle for 4 WAIT_MOVE cycles -> timeout pulse, turn=2, board unchanged.
REQ-040 Assert rst in the APPLY cycle -> next cycle state=IDLE, all outputs 0, the latched move not written.
